alu16_seq: RTL



---
 rtl/alu16_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu16_seq.sv
// 16-bit operation sequencer driving an external 8-bit combinational ALU one byte
// per pass, with extra passes to chain carries and shifted-out bits between bytes.
module alu16_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_l,
  input  logic [15:0] i_r,
  input  logic        i_cin,
  output logic [7:0]  o_alu_l,
  output logic [7:0]  o_alu_r,
  output logic [2:0]  o_alu_op,
  input  logic [7:0]  i_alu,
  input  logic [2:0]  i_alu_flags,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_res,
  output logic [2:0]  o_flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S1F  = 3'd2,
    S2   = 3'd3,
    S2F  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_r, state_nx;
  logic [2:0]  op_r;
  logic [15:0] l_r, r_r;
  logic        cin_r;
  logic [7:0]  lo_r, hi_r, lo_nx, hi_nx;
  logic        c_lo_r, c_hi_r, c_lo_nx, c_hi_nx;
  logic        accept_s;
  logic        carry_s;
  logic [2:0]  op_s;
  logic [15:0] l_s, r_s;
  logic [15:0] res_nx;
  logic [18:0] drive_s;
  logic        unused_flags_s;

  assign carry_s        = i_alu_flags[1];
  assign unused_flags_s = ^{i_alu_flags[2], i_alu_flags[0]};
  assign accept_s       = i_valid && (state_r == IDLE);
  assign op_s           = accept_s ? i_op : op_r;
  assign l_s            = accept_s ? i_l  : l_r;
  assign r_s            = accept_s ? i_r  : r_r;
  assign res_nx         = {hi_nx, lo_nx};

  // ALU port values {l, r, op} for the pass performed while in state st.
  function automatic logic [18:0] alu_drive(input state_t st, input logic [2:0] op,
                                            input logic [15:0] l, input logic [15:0] r,
                                            input logic [7:0] lo, input logic [7:0] hi);
    logic [18:0] d;
    d = 19'd0;
    case (st)
      S1: begin
        case (op)
          OP_LSR:         d = {l[15:8], 8'h00, OP_LSR};
          OP_LSL:         d = {l[7:0], 8'h00, OP_LSL};
          OP_ADD, OP_ADC: d = {l[7:0], r[7:0], OP_ADD};
          default:        d = {l[7:0], r[7:0], op};
        endcase
      end
      S1F: d = {lo, 8'h01, OP_ADD};
      S2: begin
        case (op)
          OP_LSR:         d = {l[7:0], 8'h00, OP_LSR};
          OP_LSL:         d = {l[15:8], 8'h00, OP_LSL};
          OP_ADD, OP_ADC: d = {l[15:8], r[15:8], OP_ADD};
          default:        d = {l[15:8], r[15:8], op};
        endcase
      end
      S2F: begin
        case (op)
          OP_LSR:  d = {lo, 8'h80, OP_OR};
          OP_LSL:  d = {hi, 8'h01, OP_OR};
          default: d = {hi, 8'h01, OP_ADD};
        endcase
      end
      default: d = 19'd0;
    endcase
    return d;
  endfunction

  // Next state and next intermediate bytes/carries from the current ALU pass.
  always_comb begin
    state_nx = state_r;
    lo_nx    = lo_r;
    hi_nx    = hi_r;
    c_lo_nx  = c_lo_r;
    c_hi_nx  = c_hi_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          lo_nx    = 8'h00;
          hi_nx    = 8'h00;
          c_lo_nx  = 1'b0;
          c_hi_nx  = 1'b0;
          state_nx = (i_op == OP_RSV) ? DONE : S1;
        end else begin
          state_nx = IDLE;
        end
      end
      S1: begin
        case (op_r)
          OP_LSR: begin
            hi_nx    = i_alu;
            c_lo_nx  = carry_s;
            state_nx = S2;
          end
          OP_ADD, OP_ADC, OP_LSL: begin
            lo_nx    = i_alu;
            c_lo_nx  = carry_s;
            state_nx = ((op_r == OP_ADC) && cin_r) ? S1F : S2;
          end
          default: begin
            lo_nx    = i_alu;
            c_lo_nx  = 1'b0;
            state_nx = S2;
          end
        endcase
      end
      S1F: begin
        lo_nx    = i_alu;
        c_lo_nx  = c_lo_r | carry_s;
        state_nx = S2;
      end
      S2: begin
        case (op_r)
          OP_ADD, OP_ADC, OP_LSL: begin
            hi_nx    = i_alu;
            c_hi_nx  = carry_s;
            state_nx = c_lo_r ? S2F : DONE;
          end
          OP_LSR: begin
            lo_nx    = i_alu;
            c_hi_nx  = carry_s;
            state_nx = c_lo_r ? S2F : DONE;
          end
          default: begin
            hi_nx    = i_alu;
            c_hi_nx  = 1'b0;
            state_nx = DONE;
          end
        endcase
      end
      S2F: begin
        case (op_r)
          OP_LSR: lo_nx = i_alu;
          OP_LSL: hi_nx = i_alu;
          default: begin
            hi_nx   = i_alu;
            c_hi_nx = c_hi_r | carry_s;
          end
        endcase
        state_nx = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign drive_s = alu_drive(state_nx, op_s, l_s, r_s, lo_nx, hi_nx);

  // State, request latch and intermediate registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      op_r    <= 3'd0;
      l_r     <= 16'h0000;
      r_r     <= 16'h0000;
      cin_r   <= 1'b0;
      lo_r    <= 8'h00;
      hi_r    <= 8'h00;
      c_lo_r  <= 1'b0;
      c_hi_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      lo_r    <= lo_nx;
      hi_r    <= hi_nx;
      c_lo_r  <= c_lo_nx;
      c_hi_r  <= c_hi_nx;
      if (accept_s) begin
        op_r  <= i_op;
        l_r   <= i_l;
        r_r   <= i_r;
        cin_r <= i_cin;
      end
    end
  end

  // Registered outputs; result and flags load only on entry to DONE, so the
  // reserved op (internal bytes cleared at accept) yields 0x0000 with Z=1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_res    <= 16'h0000;
      o_flags  <= 3'b000;
      o_alu_l  <= 8'h00;
      o_alu_r  <= 8'h00;
      o_alu_op <= 3'd0;
    end else begin
      o_ready  <= (state_nx == IDLE);
      o_valid  <= (state_nx == DONE);
      o_alu_l  <= drive_s[18:11];
      o_alu_r  <= drive_s[10:3];
      o_alu_op <= drive_s[2:0];
      if ((state_nx == DONE) && (state_r != DONE)) begin
        o_res   <= res_nx;
        o_flags <= {res_nx[15], c_hi_nx, (res_nx == 16'h0000)};
      end
    end
  end

endmodule
